// File: rtl/serconv_pkg.sv
// serconv_pkg: shared state encodings and helpers for serconv_dedup
// The parity helper zero-extends its argument, so it suits any WIDTH up to 64.
package serconv_pkg;

  typedef enum logic [0:0] {
    RX_IDLE,
    RX_DATA
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR
  } tx_state_t;

  localparam int PAR_W = 64;

  function automatic logic parity(input logic [PAR_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serconv_dedup_if.sv
// serconv_dedup_if: serial input, serial output and status of the converter
// master drives x/tx_en, slave is the converter itself
interface serconv_dedup_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH + 1);

  logic          x;
  logic          tx_en;
  logic          y;
  logic          tx_active;
  logic [LW-1:0] fifo_level;
  logic          dup;
  logic          ovf;

  modport master (
    output x, tx_en,
    input  y, tx_active, fifo_level, dup, ovf
  );

  modport slave (
    input  x, tx_en,
    output y, tx_active, fifo_level, dup, ovf
  );

endinterface

// File: rtl/serconv_fifo.sv
// serconv_fifo: DEPTH x WIDTH synchronous FIFO with occupancy count
// dout shows the head entry combinationally; push when full and pop when empty are ignored.
module serconv_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = level_q == LW'(DEPTH);
  assign empty   = level_q == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = level_q;
  assign dout    = mem_q[rd_q];

  // storage, written on an accepted push
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // pointers and occupancy; DEPTH is a power of 2 so pointers wrap freely
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/serconv_dedup.sv
// serconv_dedup: serial word converter with duplicate suppression and FIFO
// Optional macro SERCONV_PARITY_EN appends an even-parity bit to TX frames.
module serconv_dedup
  import serconv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic            clock,
  input logic            reset,
  serconv_dedup_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int LW = $clog2(DEPTH + 1);

  rx_state_t        rx_st_q;
  logic [CW-1:0]    rx_cnt_q;
  logic [WIDTH-2:0] rx_sh_q;
  logic [WIDTH-1:0] last_q;
  logic             old_valid_q;
  logic             dup_q;
  logic             ovf_q;

  tx_state_t        tx_st_q;
  logic [CW-1:0]    tx_cnt_q;
  logic [WIDTH-1:0] tx_sh_q;
  logic             y_q;
  logic             act_q;
`ifdef SERCONV_PARITY_EN
  logic             par_q;
`endif

  logic [WIDTH-1:0] word;
  logic             rx_done;
  logic             is_dup;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] fifo_dout;
  logic [LW-1:0]    level;
  logic             full;
  logic             empty;

  // the bit on x this cycle completes the word when the counter is at the end
  assign word    = {bus.x, rx_sh_q};
  assign rx_done = (rx_st_q == RX_DATA) && (rx_cnt_q == CW'(WIDTH - 1));
  assign is_dup  = old_valid_q && (word == last_q);
  assign push    = rx_done && !is_dup && !full;
  assign pop     = (tx_st_q == TX_IDLE) && !empty && bus.tx_en;

  serconv_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (word),
    .dout (fifo_dout),
    .level(level),
    .full (full),
    .empty(empty)
  );

  // RX deframer plus duplicate/overflow decision at word completion
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_st_q     <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_sh_q     <= '0;
      last_q      <= '0;
      old_valid_q <= 1'b0;
      dup_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      dup_q <= rx_done && is_dup;
      ovf_q <= rx_done && !is_dup && full;
      unique case (rx_st_q)
        RX_IDLE: begin
          if (bus.x) begin
            rx_st_q  <= RX_DATA;
            rx_cnt_q <= '0;
          end
        end
        RX_DATA: begin
          rx_sh_q  <= word[WIDTH-1:1];
          rx_cnt_q <= rx_cnt_q + 1'b1;
          if (rx_done) begin
            rx_st_q <= RX_IDLE;
            if (!is_dup) begin
              last_q      <= word;
              old_valid_q <= 1'b1;
            end
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  // TX framer: start bit, data LSB first, optional parity, then idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_sh_q  <= '0;
      y_q      <= 1'b0;
      act_q    <= 1'b0;
`ifdef SERCONV_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      unique case (tx_st_q)
        TX_IDLE: begin
          if (pop) begin
            tx_st_q <= TX_START;
            tx_sh_q <= fifo_dout;
            y_q     <= 1'b1;
            act_q   <= 1'b1;
`ifdef SERCONV_PARITY_EN
            par_q   <= parity(PAR_W'(fifo_dout));
`endif
          end
        end
        TX_START: begin
          tx_st_q  <= TX_DATA;
          y_q      <= tx_sh_q[0];
          tx_sh_q  <= tx_sh_q >> 1;
          tx_cnt_q <= '0;
        end
        TX_DATA: begin
          if (tx_cnt_q == CW'(WIDTH - 1)) begin
`ifdef SERCONV_PARITY_EN
            tx_st_q <= TX_PAR;
            y_q     <= par_q;
`else
            tx_st_q <= TX_IDLE;
            y_q     <= 1'b0;
            act_q   <= 1'b0;
`endif
          end else begin
            y_q      <= tx_sh_q[0];
            tx_sh_q  <= tx_sh_q >> 1;
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
`ifdef SERCONV_PARITY_EN
        TX_PAR: begin
          tx_st_q <= TX_IDLE;
          y_q     <= 1'b0;
          act_q   <= 1'b0;
        end
`endif
        default: begin
          tx_st_q <= TX_IDLE;
          y_q     <= 1'b0;
          act_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y          = y_q;
  assign bus.tx_active  = act_q;
  assign bus.fifo_level = level;
  assign bus.dup        = dup_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: doc/serconv_dedup.md
# serconv_dedup

Parametrised serial-to-serial word converter with duplicate suppression and output buffering. It deserialises framed words arriving on `x` and compares each with the last accepted word. Differing words go into a DEPTH-entry FIFO, and the FIFO is re-serialised on `y`. It is the next generation of the team's fixed 8-bit serial converter: width is generic, RX and TX overlap, and it adds downstream flow control and overflow/duplicate reporting.

## Interface
- WIDTH, 8, data bits per frame (≥2)
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- x  in  1  serial input; idle 0
- tx_en  in  1  downstream ready; when 0, no new TX frame starts
- y  out  1  serial output; idle 0
- tx_active  out  1  high from start bit through last bit of a TX frame
- fifo_level  out  $clog2(DEPTH+1)  words buffered
- dup  out  1  one-cycle pulse: received word discarded as duplicate
- ovf  out  1  one-cycle pulse: received word dropped, FIFO full

## Operation
- **Frame format, both directions:** start bit 1, then WIDTH data bits LSB first. With parity enabled, TX appends one parity bit. RX never carries parity.
- **Reset values:** RX/TX FSMs idle, y=0, tx_active=0, fifo_level=0, dup=ovf=0, last-word register 0, old_valid=0.
- **RX FSM:**
  - RX_IDLE → RX_DATA when x=1 is sampled. A bit counter runs 0..WIDTH-1 with bits shifted in LSB first.
  - The edge that samples bit WIDTH-1 completes the word: decision is made on {x, shift[WIDTH-1:1]}, and the FSM returns to RX_IDLE.
  - The next start bit may be sampled in the very next cycle, so back-to-back frames need no gap.
- **Decision at word completion, priority order:**
  1. old_valid=1 and word==last → discard; dup=1 next cycle; last unchanged.
  2. FIFO full (level before the edge == DEPTH) → drop; ovf=1 next cycle; last and old_valid are still updated.
  3. Otherwise → push; last=word; old_valid=1.
- The first word after reset is never a duplicate, including 0.
- **TX FSM:**
  - TX_IDLE: pops when FIFO non-empty and tx_en=1.
  - TX_START: y=1.
  - TX_DATA: WIDTH cycles, LSB first.
  - TX_PAR: only if enabled.
  - Then back to TX_IDLE, so there is at least one y=0 cycle between frames.
  - tx_en is checked only in TX_IDLE; a frame already started always completes.
- **Simultaneous push and pop:** both occur. Full is evaluated on the pre-edge level, so a push is dropped when level==DEPTH even if a pop happens on the same edge.

## Timing
- Push is visible in fifo_level after the edge that sampled the last data bit (E).
- Earliest pop is at edge E+1. The start bit is on y in the cycle after E+1.
- So the first y data bit appears 3 cycles after the last x data bit is sampled.
- TX frame: 1+WIDTH cycles, plus 1 with parity; 1 idle cycle before the next frame.
- dup/ovf: asserted for exactly the cycle after E.
- Reset mid-frame, at any time: all state returns to reset values immediately. A partial RX word is lost, FIFO contents are lost, and y drops to 0 asynchronously.

## Configuration
- **SERCONV_PARITY_EN defined:** TX appends an even-parity bit (XOR of data bits) after the data bits. Frame is WIDTH+2 cycles; TX_PAR state exists.
- **Undefined:** no parity bit, and TX_PAR is absent.
- RX is identical in both builds.

## Structure
- **Package serconv_pkg:**
  - rx_state_t (RX_IDLE, RX_DATA)
  - tx_state_t (TX_IDLE, TX_START, TX_DATA, TX_PAR)
  - parity function
- **Sub-module serconv_fifo:** synchronous DEPTH×WIDTH FIFO.
  - Inputs: push, pop, din.
  - Outputs: dout, level, full, empty.
  - Same clock and reset as the top.
- Top contains the RX FSM, dedup compare, TX FSM and counters.

## Test plan
All tests use WIDTH=8, DEPTH=4.
- **Reset:** assert reset mid-TX → y=0, tx_active=0, fifo_level=0 immediately. After release with idle x, y stays 0.
- **Single frame:** x=1 then 1,0,1,0,0,1,0,1 (0xA5), tx_en=1 → y start bit 2 cycles after the last data bit, then 1,0,1,0,0,1,0,1. With parity, 0 follows.
- **Duplicate:** 0xA5, 0xA5, 0x3C back-to-back → dup pulses once after the second frame; y carries only 0xA5 then 0x3C.
- **First-word zero:** 0x00 immediately after reset → accepted, transmitted as start bit plus eight 0s; no dup.
- **Overflow:** tx_en=0, distinct 0x01..0x05 → level reaches 4; ovf pulses after 0x05. Then a sixth frame 0x05 → dup (last was updated). Then tx_en=1 → 0x01..0x04 out in order.
- **Full/pop edge:** level=4, TX pops on the same edge a new distinct word completes → word dropped, ovf=1, level=3.
